// File: rtl/comp_serial_lsb.sv
// comp_serial_lsb: LSB-first iterative magnitude comparator, 2 bits/cycle, start/busy/done handshake, registered eq/gt/lt; define COMP_SIGNED_EN for two's complement operands (ports: clock, reset, start, in1, in2 -> busy, done, eq, gt, lt)
module comp_serial_lsb #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);
  localparam int N = WIDTH / 2;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] a, b;
  logic run_gt, run_lt, last, differ, slice_gt, nxt_gt, nxt_lt;
  always_comb begin
    last = k == KW'(N - 1);
    differ = a[1:0] != b[1:0];
`ifdef COMP_SIGNED_EN
    slice_gt = (last && a[1] != b[1]) ? ~a[1] : a[1:0] > b[1:0];
`else
    slice_gt = a[1:0] > b[1:0];
`endif
    nxt_gt = differ ? slice_gt : run_gt;
    nxt_lt = differ ? ~slice_gt : run_lt;
  end
  assign busy = state == EVAL;
  assign done = state == DONE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      a <= '0;
      b <= '0;
      run_gt <= 1'b0;
      run_lt <= 1'b0;
      eq <= 1'b0;
      gt <= 1'b0;
      lt <= 1'b0;
    end else if (state != EVAL && start) begin
      state <= EVAL;
      k <= '0;
      a <= in1;
      b <= in2;
      run_gt <= 1'b0;
      run_lt <= 1'b0;
    end else if (state == EVAL) begin
      a <= a >> 2;
      b <= b >> 2;
      run_gt <= nxt_gt;
      run_lt <= nxt_lt;
      if (last) begin
        state <= DONE;
        eq <= ~(nxt_gt | nxt_lt);
        gt <= nxt_gt;
        lt <= nxt_lt;
      end else begin
        k <= k + KW'(1);
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_comp_serial_lsb.sv
// tb_comp_serial_lsb: directed self-checking bench for comp_serial_lsb
module tb_comp_serial_lsb;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic busy, done, eq, gt, lt;
  int checks = 0, errors = 0;

  localparam logic [2:0] F_EQ = 3'b100, F_GT = 3'b010, F_LT = 3'b001;

  comp_serial_lsb #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    in1 = a;
    in2 = b;
    start = 1'b1;
    step();
    start = 1'b0;
    in1 = ~a;
    in2 = ~b;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, done, eq, gt, lt});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_small();
    int n;
    launch(32'd5, 32'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL small_busy: got %b want 1", busy);
    end
    wait_done(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL small_latency: got %0d want 16", n);
    end
    checks++;
    if ({busy, eq, gt, lt} !== 4'b0010) begin
      errors++;
      $display("FAIL small_flags: got busy,eq,gt,lt=%b want 0010", {busy, eq, gt, lt});
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL small_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_equal();
    int n;
    launch(32'hDEADBEEF, 32'hDEADBEEF);
    wait_done(n);
    checks++;
    if ({eq, gt, lt} !== F_EQ || n !== 16) begin
      errors++;
      $display("FAIL equal_result: got flags=%b lat=%0d want %b lat=16", {eq, gt, lt}, n, F_EQ);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({done, eq, gt, lt} !== {1'b0, F_EQ}) begin
        errors++;
        $display("FAIL equal_hold[%0d]: got done,flags=%b want 0100", i, {done, eq, gt, lt});
      end
    end
  endtask

  task automatic test_override();
    int n;
    launch(32'h10000000, 32'h0FFFFFFF);
    wait_done(n);
    checks++;
    if ({eq, gt, lt} !== F_GT || n !== 16) begin
      errors++;
      $display("FAIL override_high: got flags=%b lat=%0d want %b lat=16", {eq, gt, lt}, n, F_GT);
    end
    step();
    launch(32'h00000002, 32'h00000003);
    wait_done(n);
    checks++;
    if ({eq, gt, lt} !== F_LT || n !== 16) begin
      errors++;
      $display("FAIL override_low: got flags=%b lat=%0d want %b lat=16", {eq, gt, lt}, n, F_LT);
    end
    step();
  endtask

  task automatic test_sign();
    int n;
    logic [2:0] exp_sign;
`ifdef COMP_SIGNED_EN
    exp_sign = F_LT;
`else
    exp_sign = F_GT;
`endif
    launch(32'h80000000, 32'h00000001);
    wait_done(n);
    checks++;
    if ({eq, gt, lt} !== exp_sign) begin
      errors++;
      $display("FAIL sign_msb: got %b want %b", {eq, gt, lt}, exp_sign);
    end
    step();
    launch(32'hFFFFFFFE, 32'hFFFFFFFF);
    wait_done(n);
    checks++;
    if ({eq, gt, lt} !== F_LT) begin
      errors++;
      $display("FAIL sign_neg: got %b want %b", {eq, gt, lt}, F_LT);
    end
    step();
  endtask

  task automatic test_ignored_start();
    int n;
    launch(32'd7, 32'd9);
    for (int i = 0; i < 4; i++) step();
    in1 = 32'd9;
    in2 = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_busy: got busy,done=%b want 10", {busy, done});
    end
    wait_done(n);
    checks++;
    if (n + 5 !== 16 || {eq, gt, lt} !== F_LT) begin
      errors++;
      $display("FAIL ignored_result: got lat=%0d flags=%b want lat=16 flags=%b", n + 5, {eq, gt, lt}, F_LT);
    end
    step();
  endtask

  task automatic test_mid_reset();
    int seen;
    launch(32'd5, 32'd3);
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_clear: got %b want 00000", {busy, done, eq, gt, lt});
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d done pulses want 0", seen);
    end
    reset = 1'b1;
    start = 1'b1;
    in1 = 32'd1;
    in2 = 32'd2;
    step();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: got busy=%b want 0", busy);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    in1 = 32'd5;
    in2 = 32'd3;
    start = 1'b1;
    step();
    wait_done(n);
    checks++;
    if (n !== 16 || {eq, gt, lt} !== F_GT) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d flags=%b want lat=16 flags=%b", n, {eq, gt, lt}, F_GT);
    end
    in1 = 32'd2;
    in2 = 32'd9;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if ({busy, eq, gt, lt} !== {1'b1, F_GT}) begin
      errors++;
      $display("FAIL b2b_flags_stable: got busy,flags=%b want 1010", {busy, eq, gt, lt});
    end
    wait_done(n);
    start = 1'b0;
    checks++;
    if (n + 8 !== 17 || {eq, gt, lt} !== F_LT) begin
      errors++;
      $display("FAIL b2b_second: got gap=%0d flags=%b want gap=17 flags=%b", n + 8, {eq, gt, lt}, F_LT);
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_stop: got busy,done=%b want 00", {busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_equal();
    test_override();
    test_sign();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
